// File: rtl/xgs_pattern_pkg.sv
// Shared types and constants for the XGS multi-lane test-pattern generator.
package xgs_pattern_pkg;

  typedef enum logic [1:0] {
    PAT_RAMP    = 2'd0,
    PAT_FIXED   = 2'd1,
    PAT_CHECKER = 2'd2,
    PAT_LFSR    = 2'd3
  } pattern_mode_t;

  typedef enum logic [1:0] {
    StIdle,
    StLine,
    StGap
  } gen_state_t;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // Taps for x^16 + x^14 + x^13 + x^11 + 1, bit 15 being the x^16 term.
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic logic [15:0] lfsr_step(input logic [15:0] cur);
    return {cur[14:0], ^(cur & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/xgs_pattern_pix.sv
// Combinational pixel function for one lane of the pattern generator.
module xgs_pattern_pix
  import xgs_pattern_pkg::*;
#(
  parameter int unsigned PIX_WIDTH = 12,
  parameter int unsigned X_BITS    = 13,
  parameter int unsigned Y_BITS    = 12
) (
  input  pattern_mode_t        mode_i,
  input  logic [X_BITS-1:0]    x_i,
  input  logic [Y_BITS-1:0]    y_i,
  input  logic [15:0]          lfsr_i,
  input  logic [PIX_WIDTH-1:0] fixed_i,
  input  logic [7:0]           lane_i,
  output logic [PIX_WIDTH-1:0] pix_o
);

  logic [PIX_WIDTH-1:0] p;
  logic [PIX_WIDTH-1:0] y_trunc;
  logic [31:0]          lfsr_ext;
  logic                 unused_lfsr_hi;

  assign p              = PIX_WIDTH'(x_i) + PIX_WIDTH'(lane_i);
  assign y_trunc        = PIX_WIDTH'(y_i);
  assign lfsr_ext       = {16'h0000, lfsr_i};
  assign unused_lfsr_hi = ^lfsr_ext[31:PIX_WIDTH];

  always_comb begin
    pix_o = '0;
    unique case (mode_i)
      PAT_RAMP:    pix_o = p + y_trunc;
      PAT_FIXED:   pix_o = fixed_i;
      PAT_CHECKER: pix_o = (p[3] ^ y_i[3]) ? '1 : '0;
      PAT_LFSR:    pix_o = lfsr_ext[PIX_WIDTH-1:0] ^ PIX_WIDTH'(lane_i);
      default:     pix_o = '0;
    endcase
  end

endmodule

// File: rtl/xgs_pattern_gen.sv
// Multi-lane frame pattern source: FSM, position counters, LFSR and registered AXI-stream outputs.
module xgs_pattern_gen
  import xgs_pattern_pkg::*;
#(
  parameter int unsigned NB_LANES  = 4,
  parameter int unsigned PIX_WIDTH = 12,
  parameter int unsigned X_BITS    = 13,
  parameter int unsigned Y_BITS    = 12,
  parameter int unsigned LINE_GAP  = 8
) (
  input  logic                          sys_clk,
  input  logic                          sys_reset_n,
  input  logic                          cfg_enable,
  input  logic [1:0]                    cfg_mode,
  input  logic [X_BITS-1:0]             cfg_x_size,
  input  logic [Y_BITS-1:0]             cfg_y_size,
  input  logic [PIX_WIDTH-1:0]          cfg_fixed_value,
  input  logic                          start,
  output logic                          busy,
  output logic                          m_tvalid,
  input  logic                          m_tready,
  output logic [NB_LANES*PIX_WIDTH-1:0] m_tdata,
  output logic                          m_tuser,
  output logic                          m_tlast,
  output logic [15:0]                   frame_cnt
);

  localparam int unsigned       GapW     = (LINE_GAP > 1) ? $clog2(LINE_GAP) : 1;
  localparam logic [X_BITS-1:0] LaneStep = X_BITS'(NB_LANES);
  localparam logic [X_BITS-1:0] LaneMask = ~X_BITS'(NB_LANES - 1);

  gen_state_t                    state_q, state_d;
  logic [X_BITS-1:0]             x_q, x_d, xsize_q, xsize_d;
  logic [Y_BITS-1:0]             y_q, y_d, ysize_q, ysize_d;
  logic [15:0]                   lfsr_q, lfsr_d;
  logic [GapW-1:0]               gap_q, gap_d;
  pattern_mode_t                 mode_q, mode_d;
  logic [PIX_WIDTH-1:0]          fixed_q, fixed_d;
  logic                          busy_q, busy_d;
  logic [15:0]                   frame_cnt_q, frame_cnt_d;
  logic                          valid_q, valid_d, user_q, user_d, last_q, last_d;
  logic [NB_LANES*PIX_WIDTH-1:0] data_q, data_d, pix_word;
  logic                          accept, eol;
  logic [X_BITS-1:0]             x_eff;

  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    y_d         = y_q;
    xsize_d     = xsize_q;
    ysize_d     = ysize_q;
    lfsr_d      = lfsr_q;
    gap_d       = gap_q;
    mode_d      = mode_q;
    fixed_d     = fixed_q;
    busy_d      = busy_q;
    frame_cnt_d = frame_cnt_q;
    accept      = valid_q & m_tready;
    eol         = (x_q == xsize_q - LaneStep);
    x_eff       = cfg_x_size & LaneMask;

    unique case (state_q)
      StIdle: begin
        if (start && cfg_enable && (x_eff >= LaneStep) && (cfg_y_size != '0)) begin
          xsize_d = x_eff;
          ysize_d = cfg_y_size;
          mode_d  = pattern_mode_t'(cfg_mode);
          fixed_d = cfg_fixed_value;
          x_d     = '0;
          y_d     = '0;
          lfsr_d  = LFSR_SEED;
          busy_d  = 1'b1;
          state_d = StLine;
        end
      end
      StLine: begin
        if (accept) begin
          lfsr_d = lfsr_step(lfsr_q);
          if (!eol) begin
            x_d = x_q + LaneStep;
          end else if (y_q == ysize_q - Y_BITS'(1)) begin
            state_d     = StIdle;
            busy_d      = 1'b0;
            frame_cnt_d = frame_cnt_q + 16'd1;
          end else if (!cfg_enable) begin
            // Abort: the line just finished cleanly, the frame is not counted.
            state_d = StIdle;
            busy_d  = 1'b0;
          end else begin
            x_d     = '0;
            y_d     = y_q + Y_BITS'(1);
            gap_d   = '0;
            state_d = (LINE_GAP == 0) ? StLine : StGap;
          end
        end
      end
      StGap: begin
        gap_d = gap_q + GapW'(1);
        if (gap_q == GapW'(LINE_GAP - 1)) begin
          state_d = StLine;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Lanes are evaluated on next-state position so the beat is registered as it is presented.
  for (genvar k = 0; k < NB_LANES; k++) begin : g_lane
    xgs_pattern_pix #(
      .PIX_WIDTH(PIX_WIDTH),
      .X_BITS   (X_BITS),
      .Y_BITS   (Y_BITS)
    ) u_pix (
      .mode_i (mode_d),
      .x_i    (x_d),
      .y_i    (y_d),
      .lfsr_i (lfsr_d),
      .fixed_i(fixed_d),
      .lane_i (8'(k)),
      .pix_o  (pix_word[k*PIX_WIDTH +: PIX_WIDTH])
    );
  end

  always_comb begin
    valid_d = (state_d == StLine);
    data_d  = valid_d ? pix_word : '0;
    user_d  = valid_d && (x_d == '0) && (y_d == '0);
    last_d  = valid_d && (x_d == xsize_d - LaneStep);
  end

  always_ff @(posedge sys_clk or negedge sys_reset_n) begin
    if (!sys_reset_n) begin
      state_q     <= StIdle;
      x_q         <= '0;
      y_q         <= '0;
      xsize_q     <= '0;
      ysize_q     <= '0;
      lfsr_q      <= LFSR_SEED;
      gap_q       <= '0;
      mode_q      <= PAT_RAMP;
      fixed_q     <= '0;
      busy_q      <= 1'b0;
      frame_cnt_q <= '0;
      valid_q     <= 1'b0;
      data_q      <= '0;
      user_q      <= 1'b0;
      last_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      y_q         <= y_d;
      xsize_q     <= xsize_d;
      ysize_q     <= ysize_d;
      lfsr_q      <= lfsr_d;
      gap_q       <= gap_d;
      mode_q      <= mode_d;
      fixed_q     <= fixed_d;
      busy_q      <= busy_d;
      frame_cnt_q <= frame_cnt_d;
      valid_q     <= valid_d;
      data_q      <= data_d;
      user_q      <= user_d;
      last_q      <= last_d;
    end
  end

  assign busy      = busy_q;
  assign m_tvalid  = valid_q;
  assign m_tdata   = data_q;
  assign m_tuser   = user_q;
  assign m_tlast   = last_q;
  assign frame_cnt = frame_cnt_q;

endmodule
